// File: rtl/rv_pipe_pkg.sv
// Shared pipeline constants and the hazard FSM state type.
package rv_pipe_pkg;

   localparam logic [6:0] OPC_LOAD = 7'b0000011;

   // Register-source field positions inside a 32-bit RV32I instruction.
   localparam int RS1_MSB = 19;
   localparam int RS1_LSB = 15;
   localparam int RS2_MSB = 24;
   localparam int RS2_LSB = 20;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_WAIT  = 2'd1,
      TRAP_FLUSH = 2'd2
   } hz_state_e;

endpackage

// File: rtl/fwd_match.sv
// Priority comparator for one source operand against the forwarding stages.
// Stage 0 is the youngest producer, so the lowest matching index wins.
module fwd_match
   import rv_pipe_pkg::*;
#(
   parameter int NUM_FWD = 2,
   parameter int SELW    = $clog2(NUM_FWD + 1)
) (
   input  logic [4:0]              rs,
   input  logic [NUM_FWD-1:0][4:0] fwd_rd,
   input  logic [NUM_FWD-1:0]      fwd_wren,
   output logic [SELW-1:0]         sel,
   output logic                    hit0
);

   // Scan oldest to youngest so a younger match overwrites an older one.
   always_comb begin
      sel = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if ((rs != 5'd0) && fwd_wren[k] && (fwd_rd[k] == rs)) begin
            sel = SELW'(k + 1);
         end
      end
      hit0 = (rs != 5'd0) && fwd_wren[0] && (fwd_rd[0] == rs);
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Forwarding select, load-use stall FSM with timeout, and trap/branch flush
// sequencing for the ID/EX boundary.
module hazard_ctrl_unit
   import rv_pipe_pkg::*;
#(
   parameter int NUM_FWD      = 2,
   parameter int FLUSH_CYCLES = 2,
   parameter int LOAD_TIMEOUT = 15,
   parameter int SELW         = $clog2(NUM_FWD + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             ir_id,
   input  logic [NUM_FWD-1:0][4:0] fwd_rd,
   input  logic [NUM_FWD-1:0]      fwd_wren,
   input  logic [NUM_FWD-1:0]      fwd_is_load,
   input  logic                    mem_valid,
   input  logic                    br_taken,
   input  logic                    interrupt,
   input  logic                    is_mret,
   input  logic                    epc_taken,
   output logic [SELW-1:0]         fwd_sel_a,
   output logic [SELW-1:0]         fwd_sel_b,
   output logic                    stall_if,
   output logic                    stall_ex,
   output logic                    flush,
   output logic                    load_timeout
);

   localparam int WCW = $clog2(LOAD_TIMEOUT + 1);
   localparam int FCW = $clog2(FLUSH_CYCLES + 1);
   localparam logic [WCW-1:0] WAIT_MAX     = WCW'(LOAD_TIMEOUT);
   localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_CYCLES - 1);
   // A single-cycle trap flush finishes in the accept cycle itself.
   localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);

   hz_state_e      state_q, state_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic [FCW-1:0] flush_cnt_q, flush_cnt_d;

   logic [SELW-1:0] sel_a, sel_b;
   logic            hit0_a, hit0_b;
   logic            hz, redirect;
   logic            stall_if_c, stall_ex_c, flush_c, timeout_c;
   logic            unused_bits;

   assign unused_bits = ^{ir_id[31:RS2_MSB+1], ir_id[RS1_LSB-1:0], fwd_is_load};

   fwd_match #(.NUM_FWD(NUM_FWD), .SELW(SELW)) u_match_a (
      .rs       (ir_id[RS1_MSB:RS1_LSB]),
      .fwd_rd   (fwd_rd),
      .fwd_wren (fwd_wren),
      .sel      (sel_a),
      .hit0     (hit0_a)
   );

   fwd_match #(.NUM_FWD(NUM_FWD), .SELW(SELW)) u_match_b (
      .rs       (ir_id[RS2_MSB:RS2_LSB]),
      .fwd_rd   (fwd_rd),
      .fwd_wren (fwd_wren),
      .sel      (sel_b),
      .hit0     (hit0_b)
   );

   // Load-use hazard: a source needs the stage-0 load whose data is not back yet.
   assign hz       = (hit0_a | hit0_b) & fwd_is_load[0] & ~mem_valid;
   // A taken branch is ignored while the PC is being redirected to epc.
   assign redirect = is_mret | (br_taken & ~epc_taken);

   // Next-state, counter and control decode; priority interrupt > redirect > hazard.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      flush_cnt_d = flush_cnt_q;
      stall_if_c  = 1'b0;
      stall_ex_c  = 1'b0;
      flush_c     = 1'b0;
      timeout_c   = 1'b0;
      case (state_q)
         RUN, LOAD_WAIT: begin
            if (interrupt) begin
               flush_c     = 1'b1;
               stall_if_c  = 1'b1;
               stall_ex_c  = 1'b1;
               wait_cnt_d  = '0;
               flush_cnt_d = FLUSH_RELOAD;
               state_d     = MULTI_FLUSH ? TRAP_FLUSH : RUN;
            end else if (redirect) begin
               flush_c    = 1'b1;
               stall_if_c = 1'b1;
               wait_cnt_d = '0;
               state_d    = RUN;
            end else if (state_q == RUN) begin
               if (hz) begin
                  stall_if_c = 1'b1;
                  stall_ex_c = 1'b1;
                  wait_cnt_d = WCW'(1);
                  state_d    = LOAD_WAIT;
               end
            end else if (mem_valid) begin
               wait_cnt_d = '0;
               state_d    = RUN;
            end else if (wait_cnt_q == WAIT_MAX) begin
               timeout_c  = 1'b1;
               wait_cnt_d = '0;
               state_d    = RUN;
            end else begin
               stall_if_c = 1'b1;
               stall_ex_c = 1'b1;
               if (wait_cnt_q < WAIT_MAX) begin
                  wait_cnt_d = wait_cnt_q + WCW'(1);
               end
            end
         end
         TRAP_FLUSH: begin
            flush_c    = 1'b1;
            stall_if_c = 1'b1;
            if (interrupt) begin
               flush_cnt_d = FLUSH_RELOAD;
               if (FLUSH_RELOAD == '0) begin
                  state_d = RUN;
               end
            end else if (flush_cnt_q <= FCW'(1)) begin
               flush_cnt_d = '0;
               state_d     = RUN;
            end else begin
               flush_cnt_d = flush_cnt_q - FCW'(1);
            end
         end
         default: begin
            state_d     = RUN;
            wait_cnt_d  = '0;
            flush_cnt_d = '0;
         end
      endcase
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Every output is forced low while reset is held.
   always_comb begin
      fwd_sel_a    = rst ? '0 : sel_a;
      fwd_sel_b    = rst ? '0 : sel_b;
      stall_if     = ~rst & stall_if_c;
      stall_ex     = ~rst & stall_ex_c;
      flush        = ~rst & flush_c;
      load_timeout = ~rst & timeout_c;
   end

endmodule
